rotate_cmd_buffer: RTL and testbench

Command buffering and result-capture stage wrapped around the 8-bit rotate-right shifter. It accepts {data, shift amount} commands on a valid/ready input and queues them in a small FIFO. The FIFO head drives the shifter's inputs. The shifter's combinational result is captured into a registered valid/ready output stage, so back-to-back commands sustain one result per clock and downstream backpressure is absorbed.

---
 rtl/rotate_cmd_buffer.sv | 83 ++++++++
 tb/tb_rotate_cmd_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_cmd_buffer.sv
`timescale 1ns/1ps
// Queues {data, shift} rotate commands for an external shifter and registers its result.
// Accept->out_valid is 2 edges; in_ready drops only when the FIFO is full; !out_ready freezes the result.
module rotate_cmd_buffer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  output logic [DATA_W-1:0]        sh_x,
  output logic [SHIFT_W-1:0]       sh_shift,
  input  logic [DATA_W-1:0]        sh_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SHIFT_W-1:0]       out_shift,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0]  mem_dat [DEPTH];
  logic [SHIFT_W-1:0] mem_sh  [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               empty;
  logic               push;
  logic               pop;

  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  assign sh_x     = empty ? '0 : mem_dat[rd_ptr];
  assign sh_shift = empty ? '0 : mem_sh[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= in_data;
      mem_sh[wr_ptr]  <= in_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result register: reload on pop, otherwise clear valid once consumed and hold the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= sh_y;
      out_shift <= sh_shift;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotate_cmd_buffer.sv
`timescale 1ns/1ps
// Randomised and directed bench for rotate_cmd_buffer against a queue-based model,
// with the external shifter modelled as a combinational rotate.
module tb_rotate_cmd_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_shift = '0;
  logic [7:0] sh_x;
  logic [2:0] sh_shift;
  logic [7:0] sh_y;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [2:0] out_shift;
  logic [2:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  rotate_cmd_buffer #(.DEPTH(DEPTH), .DATA_W(8), .SHIFT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
    .sh_x(sh_x), .sh_shift(sh_shift), .sh_y(sh_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] w;
    w = {x, x} >> s;
    return w[7:0];
  endfunction

  assign sh_y = rotr(sh_x, sh_shift);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of pending commands plus one result slot.
  cmd_t       mq[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = '0;
  logic [2:0] m_os = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ov = 1'b0;
      m_od = '0;
      m_os = '0;
    end else begin
      int   n;
      logic do_pop;
      logic do_push;
      cmd_t h;
      n       = mq.size();
      do_pop  = (n > 0) && (!m_ov || out_ready);
      do_push = in_valid && (n < DEPTH);
      if (do_pop) begin
        h    = mq.pop_front();
        m_od = rotr(h.d, h.s);
        m_os = h.s;
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (do_push) mq.push_back('{d: in_data, s: in_shift});
    end
  end

  // Per-cycle comparison of every output against the model, plus handshake logging.
  cmd_t acc[$];
  cmd_t res[$];
  int   cyc = 0;
  int   max_cnt = 0;
  int   rdy_low = 0;
  int   res_cyc[$];

  always @(negedge clk) begin
    cyc++;
    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("out_shift", out_shift, m_os);
    check("count",     count,     mq.size());
    check("in_ready",  in_ready,  (mq.size() < DEPTH));
    check("sh_x",      sh_x,      mq.size() ? mq[0].d : 8'h00);
    check("sh_shift",  sh_shift,  mq.size() ? mq[0].s : 3'h0);
    if (!rst) begin
      if (in_valid && in_ready) acc.push_back('{d: in_data, s: in_shift});
      if (out_valid && out_ready) begin
        res.push_back('{d: out_data, s: out_shift});
        res_cyc.push_back(cyc);
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (!in_ready) rdy_low++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc.delete();
    res.delete();
    res_cyc.delete();
    max_cnt = 0;
    rdy_low = 0;
  endtask

  task automatic drain(input string name, input int n);
    int i;
    i = 0;
    while (res.size() < n && i < 300) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check({name, "_count"}, res.size(), n);
    check({name, "_acc"}, acc.size(), n);
    for (int k = 0; k < n && k < res.size() && k < acc.size(); k++) begin
      check({name, "_data"},  res[k].d, rotr(acc[k].d, acc[k].s));
      check({name, "_shift"}, res[k].s, acc[k].s);
    end
    tick();
  endtask

  task automatic single(input logic [7:0] d, input logic [2:0] s, input logic [7:0] exp);
    in_valid = 1'b1; in_data = d; in_shift = s;
    @(negedge clk); check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_data = $urandom; in_shift = $urandom;
    @(negedge clk); check("t1_early", out_valid, 0);
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_data",  out_data,  exp);
    check("t1_shift", out_shift, s);
    @(negedge clk); check("t1_one_cycle", out_valid, 0);
    tick();
  endtask

  initial begin
    int   acc_cnt;
    int   sent;
    int   guard;
    logic [7:0] first_res;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_sh_x", sh_x, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single commands with literal results
    out_ready = 1'b1;
    single(8'h81, 3'd1, 8'hC0);
    single(8'h12, 3'd4, 8'h21);
    single(8'h01, 3'd7, 8'h02);
    single(8'hA5, 3'd0, 8'hA5);

    // 2: streaming 16 back-to-back commands
    clear_logs();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 8'h01; in_shift = 3'(k);
      tick();
    end
    in_valid = 1'b0;
    drain("t2", 16);
    check("t2_max_count", max_cnt, 1);
    check("t2_ready_low", rdy_low, 0);
    if (res.size() == 16) begin
      check("t2_first", res[0].d, 8'h01);
      check("t2_second", res[1].d, 8'h80);
      check("t2_last", res[15].d, 8'h02);
      check("t2_consecutive", res_cyc[15] - res_cyc[0], 15);
    end else begin
      check("t2_result_count", res.size(), 16);
    end

    // 3: backpressure fills DEPTH+1 slots
    clear_logs();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_shift = 3'($urandom);
      @(negedge clk);
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_accepted", acc_cnt, 5);
    check("t3_count", count, 4);
    check("t3_in_ready", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    first_res = rotr(acc[0].d, acc[0].s);
    check("t3_first", out_data, first_res);
    repeat (3) @(negedge clk);
    check("t3_hold", out_data, first_res);
    tick();
    out_ready = 1'b1;
    drain("t3", 5);
    check("t3_ready_back", in_ready, 1);

    // 4: full FIFO with simultaneous pop: push refused, then accepted next cycle
    clear_logs();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_shift = 3'($urandom);
      tick();
    end
    out_ready = 1'b1;
    in_data = 8'h3C; in_shift = 3'd2;
    @(negedge clk);
    check("t4_count_full", count, 4);
    check("t4_not_ready", in_ready, 0);
    tick();
    check("t4_count_pop", count, 3);
    @(negedge clk);
    check("t4_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t4_count_both", count, 3);
    drain("t4", 6);

    // 5: random traffic across several pointer wraps
    clear_logs();
    sent = 0;
    guard = 0;
    while (sent < 3 * DEPTH && guard < 500) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_shift  = 3'($urandom);
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("t5_sent", sent, 3 * DEPTH);
    guard = 0;
    while (res.size() < 3 * DEPTH && guard < 300) begin
      out_ready = $urandom_range(0, 1);
      tick();
      guard++;
    end
    out_ready = 1'b1;
    drain("t5", 3 * DEPTH);

    // 6: asynchronous reset mid-operation
    clear_logs();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom) | 8'h01; in_shift = 3'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2;
    check("t6_pre_count", count, 3);
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_shift", out_shift, 0);
    check("t6_count", count, 0);
    check("t6_sh_x", sh_x, 0);
    check("t6_sh_shift", sh_shift, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_in_ready", in_ready, 1);
    tick();
    single(8'h0F, 3'd2, 8'hC3);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
